// File: rtl/cp0_exception_unit_pkg.sv
// Shared CP0 definitions: register numbers, exception codes, handler vector
// and register field positions.
package cp0_exception_unit_pkg;

  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_SR       = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;
  localparam logic [4:0] CP0_PRID     = 5'd15;

  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } exc_code_e;

  localparam logic [31:0] HANDLER_VECTOR = 32'h0000_4180;

  localparam int unsigned SR_IE        = 0;
  localparam int unsigned SR_EXL       = 1;
  localparam int unsigned SR_IM_LO     = 10;
  localparam int unsigned SR_IM_HI     = 15;
  localparam int unsigned CAUSE_EXC_LO = 2;
  localparam int unsigned CAUSE_EXC_HI = 6;
  localparam int unsigned CAUSE_IP_LO  = 10;
  localparam int unsigned CAUSE_IP_HI  = 15;
  localparam int unsigned CAUSE_BD     = 31;

  function automatic logic is_addr_err(input logic [4:0] code);
    return (code == EXC_ADEL) || (code == EXC_ADES);
  endfunction

endpackage

// File: rtl/cp0_exception_unit_int_arbiter.sv
// Combinational event arbiter: qualifies interrupts and exceptions against
// SR and picks the ExcCode to record (interrupt wins).
module cp0_int_arbiter
  import cp0_exception_unit_pkg::*;
(
  input  logic [5:0] hw_int,
  input  logic [5:0] sr_im,
  input  logic       sr_ie,
  input  logic       sr_exl,
  input  logic [4:0] exc_code_M,
  output logic       int_req,
  output logic       exc_hit,
  output logic [4:0] sel_code
);

  always_comb begin
    int_req  = (|(hw_int & sr_im)) & sr_ie & ~sr_exl;
    exc_hit  = (exc_code_M != 5'd0) & ~sr_exl;
    sel_code = int_req ? EXC_INT : exc_code_M;
  end

endmodule

// File: rtl/cp0_exception_unit.sv
// M-stage coprocessor 0: holds SR/Cause/EPC/BadVAddr/PRId, raises the
// flush/redirect request and serves mfc0/mtc0/eret.
module cp0_exception_unit
  import cp0_exception_unit_pkg::*;
#(
  parameter logic [31:0] PRID = 32'h4D49_5053
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_M,
  input  logic        bd_M,
  input  logic [4:0]  exc_code_M,
  input  logic [31:0] bad_addr_M,
  input  logic [5:0]  hw_int,
  input  logic        cp0_we,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] cp0_wdata,
  input  logic        eret_M,
  output logic [31:0] cp0_rdata,
  output logic        exc_req,
  output logic [31:0] epc_out
);

  logic [5:0]  sr_im;
  logic        sr_exl;
  logic        sr_ie;
  logic        cause_bd;
  logic [5:0]  cause_ip;
  logic [4:0]  cause_exc;
  logic [31:0] epc;
  logic [31:0] badvaddr;

  logic        int_req;
  logic        exc_hit;
  logic [4:0]  sel_code;
  logic [31:0] epc_next;
  logic [31:0] sr_val;
  logic [31:0] cause_val;

  cp0_int_arbiter u_arb (
    .hw_int     (hw_int),
    .sr_im      (sr_im),
    .sr_ie      (sr_ie),
    .sr_exl     (sr_exl),
    .exc_code_M (exc_code_M),
    .int_req    (int_req),
    .exc_hit    (exc_hit),
    .sel_code   (sel_code)
  );

  assign exc_req  = int_req | exc_hit;
  assign epc_next = (bd_M ? (pc_M - 32'd4) : pc_M) & ~32'd3;
  assign epc_out  = epc;

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_im     <= '0;
      sr_exl    <= 1'b0;
      sr_ie     <= 1'b0;
      cause_bd  <= 1'b0;
      cause_ip  <= '0;
      cause_exc <= '0;
      epc       <= '0;
      badvaddr  <= '0;
    end else begin
      cause_ip <= hw_int;
      if (exc_req) begin
        sr_exl    <= 1'b1;
        cause_bd  <= bd_M;
        cause_exc <= sel_code;
        epc       <= epc_next;
        if (is_addr_err(sel_code))
          badvaddr <= bad_addr_M;
      end else begin
        if (cp0_we && cp0_addr == CP0_SR) begin
          sr_im  <= cp0_wdata[SR_IM_HI:SR_IM_LO];
          sr_exl <= cp0_wdata[SR_EXL];
          sr_ie  <= cp0_wdata[SR_IE];
        end
        if (cp0_we && cp0_addr == CP0_EPC)
          epc <= cp0_wdata;
        // eret outranks an mtc0 SR write for the EXL bit
        if (eret_M)
          sr_exl <= 1'b0;
      end
    end
  end

  always_comb begin
    sr_val                           = '0;
    sr_val[SR_IM_HI:SR_IM_LO]        = sr_im;
    sr_val[SR_EXL]                   = sr_exl;
    sr_val[SR_IE]                    = sr_ie;
    cause_val                        = '0;
    cause_val[CAUSE_BD]              = cause_bd;
    cause_val[CAUSE_IP_HI:CAUSE_IP_LO]   = cause_ip;
    cause_val[CAUSE_EXC_HI:CAUSE_EXC_LO] = cause_exc;
  end

  always_comb begin
    cp0_rdata = '0;
    case (cp0_addr)
      CP0_BADVADDR: cp0_rdata = badvaddr;
      CP0_SR:       cp0_rdata = sr_val;
      CP0_CAUSE:    cp0_rdata = cause_val;
      CP0_EPC:      cp0_rdata = epc;
      CP0_PRID:     cp0_rdata = PRID;
      default:      cp0_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_exception_unit.sv
// Directed, table-driven bench for cp0_exception_unit: one vector per cycle,
// outputs checked before the edge that applies the vector.
module tb_cp0_exception_unit;

  localparam logic [31:0] PRID_VAL = 32'h4D49_5053;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc_M = '0;
  logic        bd_M = 1'b0;
  logic [4:0]  exc_code_M = '0;
  logic [31:0] bad_addr_M = '0;
  logic [5:0]  hw_int = '0;
  logic        cp0_we = 1'b0;
  logic [4:0]  cp0_addr = '0;
  logic [31:0] cp0_wdata = '0;
  logic        eret_M = 1'b0;
  logic [31:0] cp0_rdata;
  logic        exc_req;
  logic [31:0] epc_out;

  int passed = 0;
  int total  = 0;

  cp0_exception_unit #(.PRID(PRID_VAL)) dut (
    .clk        (clk),
    .reset      (reset),
    .pc_M       (pc_M),
    .bd_M       (bd_M),
    .exc_code_M (exc_code_M),
    .bad_addr_M (bad_addr_M),
    .hw_int     (hw_int),
    .cp0_we     (cp0_we),
    .cp0_addr   (cp0_addr),
    .cp0_wdata  (cp0_wdata),
    .eret_M     (eret_M),
    .cp0_rdata  (cp0_rdata),
    .exc_req    (exc_req),
    .epc_out    (epc_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        bd;
    logic [4:0]  code;
    logic [31:0] bad;
    logic [5:0]  hw;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic        eret;
    logic        exp_req;
    logic [31:0] exp_rdata;
    logic [31:0] exp_epc;
  } vec_t;

  localparam int NV = 32;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic [31:0] pc, input logic bd, input logic [4:0] code,
                              input logic [31:0] bad, input logic [5:0] hw, input logic we,
                              input logic [4:0] addr, input logic [31:0] wdata, input logic eret,
                              input logic exp_req, input logic [31:0] exp_rdata,
                              input logic [31:0] exp_epc);
    vec_t v;
    v.pc = pc; v.bd = bd; v.code = code; v.bad = bad; v.hw = hw; v.we = we;
    v.addr = addr; v.wdata = wdata; v.eret = eret;
    v.exp_req = exp_req; v.exp_rdata = exp_rdata; v.exp_epc = exp_epc;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input vec_t v);
    pc_M = v.pc; bd_M = v.bd; exc_code_M = v.code; bad_addr_M = v.bad; hw_int = v.hw;
    cp0_we = v.we; cp0_addr = v.addr; cp0_wdata = v.wdata; eret_M = v.eret;
  endtask

  initial begin
    //              pc           bd code  bad            hw     we addr   wdata          er  req rdata          epc
    vecs[0]  = mk(32'h0,       0, 5'd0,  32'h0,        6'h00, 0, 5'd15, 32'h0,        0,  0, PRID_VAL,      32'h0);
    vecs[1]  = mk(32'h0,       0, 5'd0,  32'h0,        6'h00, 0, 5'd12, 32'h0,        0,  0, 32'h0,         32'h0);
    vecs[2]  = mk(32'h0,       0, 5'd0,  32'h0,        6'h00, 0, 5'd13, 32'h0,        0,  0, 32'h0,         32'h0);
    vecs[3]  = mk(32'h0,       0, 5'd0,  32'h0,        6'h00, 0, 5'd14, 32'h0,        0,  0, 32'h0,         32'h0);
    vecs[4]  = mk(32'h0,       0, 5'd0,  32'h0,        6'h00, 0, 5'd8,  32'h0,        0,  0, 32'h0,         32'h0);
    vecs[5]  = mk(32'h0,       0, 5'd0,  32'h0,        6'h00, 1, 5'd12, 32'h0000_0401,0,  0, 32'h0,         32'h0);
    vecs[6]  = mk(32'h0,       0, 5'd0,  32'h0,        6'h00, 0, 5'd12, 32'h0,        0,  0, 32'h0000_0401, 32'h0);
    vecs[7]  = mk(32'h3010,    0, 5'd0,  32'h0,        6'h01, 0, 5'd13, 32'h0,        0,  1, 32'h0,         32'h0);
    vecs[8]  = mk(32'h3014,    0, 5'd0,  32'h0,        6'h01, 0, 5'd13, 32'h0,        0,  0, 32'h0000_0400, 32'h3010);
    vecs[9]  = mk(32'h3014,    0, 5'd0,  32'h0,        6'h01, 0, 5'd12, 32'h0,        0,  0, 32'h0000_0403, 32'h3010);
    vecs[10] = mk(32'h3014,    0, 5'd0,  32'h0,        6'h00, 0, 5'd14, 32'h0,        1,  0, 32'h3010,      32'h3010);
    vecs[11] = mk(32'h3040,    0, 5'd0,  32'h0,        6'h01, 0, 5'd12, 32'h0,        0,  1, 32'h0000_0401, 32'h3010);
    vecs[12] = mk(32'h3044,    0, 5'd0,  32'h0,        6'h00, 0, 5'd14, 32'h0,        1,  0, 32'h3040,      32'h3040);
    vecs[13] = mk(32'h3024,    1, 5'd12, 32'h0,        6'h00, 0, 5'd12, 32'h0,        0,  1, 32'h0000_0401, 32'h3040);
    vecs[14] = mk(32'h3028,    0, 5'd0,  32'h0,        6'h00, 0, 5'd13, 32'h0,        0,  0, 32'h8000_0030, 32'h3020);
    vecs[15] = mk(32'h3028,    0, 5'd0,  32'h0,        6'h00, 0, 5'd8,  32'h0,        1,  0, 32'h0,         32'h3020);
    vecs[16] = mk(32'h3100,    0, 5'd4,  32'h0000_1003,6'h00, 0, 5'd13, 32'h0,        0,  1, 32'h8000_0030, 32'h3020);
    vecs[17] = mk(32'h3104,    0, 5'd0,  32'h0,        6'h00, 0, 5'd8,  32'h0,        0,  0, 32'h0000_1003, 32'h3100);
    vecs[18] = mk(32'h3104,    0, 5'd0,  32'h0,        6'h00, 0, 5'd13, 32'h0,        1,  0, 32'h0000_0010, 32'h3100);
    vecs[19] = mk(32'h3200,    0, 5'd12, 32'hDEAD_BEEF,6'h00, 0, 5'd8,  32'h0,        0,  1, 32'h0000_1003, 32'h3100);
    vecs[20] = mk(32'h3204,    0, 5'd0,  32'h0,        6'h00, 0, 5'd8,  32'h0,        1,  0, 32'h0000_1003, 32'h3200);
    vecs[21] = mk(32'h3300,    0, 5'd10, 32'h0,        6'h01, 1, 5'd14, 32'h5555_5550,0,  1, 32'h3200,      32'h3200);
    vecs[22] = mk(32'h3304,    0, 5'd0,  32'h0,        6'h00, 0, 5'd13, 32'h0,        0,  0, 32'h0000_0400, 32'h3300);
    vecs[23] = mk(32'h3304,    0, 5'd0,  32'h0,        6'h00, 0, 5'd14, 32'h0,        1,  0, 32'h3300,      32'h3300);
    vecs[24] = mk(32'h0,       1, 5'd5,  32'h0000_0002,6'h00, 0, 5'd14, 32'h0,        0,  1, 32'h3300,      32'h3300);
    vecs[25] = mk(32'h4,       0, 5'd0,  32'h0,        6'h00, 0, 5'd14, 32'h0,        1,  0, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
    vecs[26] = mk(32'h4,       0, 5'd0,  32'h0,        6'h00, 1, 5'd14, 32'h0000_1235,0,  0, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
    vecs[27] = mk(32'h4,       0, 5'd0,  32'h0,        6'h00, 0, 5'd14, 32'h0,        0,  0, 32'h0000_1235, 32'h0000_1235);
    vecs[28] = mk(32'h4,       0, 5'd0,  32'h0,        6'h00, 1, 5'd12, 32'hFFFF_FFFF,0,  0, 32'h0000_0401, 32'h0000_1235);
    vecs[29] = mk(32'h4,       0, 5'd0,  32'h0,        6'h3F, 0, 5'd12, 32'h0,        0,  0, 32'h0000_FC03, 32'h0000_1235);
    vecs[30] = mk(32'h4,       0, 5'd0,  32'h0,        6'h00, 1, 5'd13, 32'hFFFF_FFFF,0,  0, 32'h8000_FC14, 32'h0000_1235);
    vecs[31] = mk(32'h4,       0, 5'd0,  32'h0,        6'h00, 0, 5'd13, 32'h0,        0,  0, 32'h8000_0014, 32'h0000_1235);

    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i]);
      #2;
      check($sformatf("v%0d_exc_req", i), {31'b0, exc_req}, {31'b0, vecs[i].exp_req});
      check($sformatf("v%0d_rdata", i), cp0_rdata, vecs[i].exp_rdata);
      check($sformatf("v%0d_epc_out", i), epc_out, vecs[i].exp_epc);
      @(negedge clk);
    end

    // Reset while EXL=1 with interrupt lines high: everything clears, IP masked.
    reset = 1'b1; hw_int = 6'h3F; cp0_we = 1'b0; eret_M = 1'b0; cp0_addr = 5'd12;
    @(negedge clk);
    reset = 1'b0; hw_int = 6'h00;
    #1 check("rst_sr", cp0_rdata, 32'h0);
    check("rst_exc_req", {31'b0, exc_req}, 32'h0);
    check("rst_epc_out", epc_out, 32'h0);
    cp0_addr = 5'd13;
    #1 check("rst_cause", cp0_rdata, 32'h0);
    cp0_addr = 5'd8;
    #1 check("rst_badvaddr", cp0_rdata, 32'h0);
    cp0_addr = 5'd14;
    #1 check("rst_epc", cp0_rdata, 32'h0);
    cp0_addr = 5'd15;
    #1 check("rst_prid", cp0_rdata, PRID_VAL);
    cp0_addr = 5'd3;
    #1 check("unmapped_read", cp0_rdata, 32'h0);

    // With SR cleared, a pending exception is taken again and IE=0 blocks interrupts.
    @(negedge clk);
    hw_int = 6'h3F;
    #1 check("post_rst_int_blocked", {31'b0, exc_req}, 32'h0);
    exc_code_M = 5'd10; pc_M = 32'h5000;
    #1 check("post_rst_ri_req", {31'b0, exc_req}, 32'h1);
    @(negedge clk);
    exc_code_M = 5'd0; hw_int = 6'h00; cp0_addr = 5'd13;
    #1 check("post_rst_ri_cause", cp0_rdata, 32'h0000_FC28);
    check("post_rst_ri_epc", epc_out, 32'h5000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/cp0_exception_unit.md
# cp0_exception_unit

Coprocessor-0 block in the memory (M) stage of the MIPS pipeline. It consumes the exception indications produced upstream: arithmetic overflow from the execute-stage ALU, address-error codes derived from the ALU byte offset, and decode-stage faults. It also takes hardware interrupt lines from the timers. It arbitrates these events, holds SR/Cause/EPC/BadVAddr/PRId, requests the pipeline flush and redirect, and serves mfc0/mtc0/eret.

## Interface
Parameters:
- `PRID`, 32'h4D49_5053: read-only processor ID value.

Ports:
- `clk` in 1: single clock. All state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `pc_M` in 32: PC of the instruction currently in M.
- `bd_M` in 1: that instruction sits in a branch delay slot.
- `exc_code_M` in 5: pending exception of the M instruction. 0 means none. Uses 4 AdEL, 5 AdES, 10 RI, 12 Ov.
- `bad_addr_M` in 32: faulting data address, valid when `exc_code_M` is 4 or 5.
- `hw_int` in 6: level interrupt lines; [0] is timer0, [1] is timer1.
- `cp0_we` in 1: mtc0 in M.
- `cp0_addr` in 5: cp0 register number for both mtc0 and mfc0.
- `cp0_wdata` in 32: mtc0 data.
- `eret_M` in 1: eret in M.
- `cp0_rdata` out 32: mfc0 read data, combinational from the current registers.
- `exc_req` out 1: flush all stages and redirect fetch to 32'h0000_4180.
- `epc_out` out 32: current EPC, used as the eret target.

## Operation
Registers:
- SR (12): IM[15:10], EXL[1], IE[0]. Other bits read 0.
- Cause (13): BD[31], IP[15:10], ExcCode[6:2]. Other bits read 0.
- EPC (14): 32 bits.
- BadVAddr (8): 32 bits.
- PRId (15): constant `PRID`.
- Any other address reads 0. mtc0 to Cause, PRId, BadVAddr or an unmapped number is ignored.

Request terms:
- int_req = |(hw_int & SR.IM) & SR.IE & ~SR.EXL.
- exc_hit = (exc_code_M != 0) & ~SR.EXL.
- `exc_req` = int_req | exc_hit, combinational.

Per-edge priority, highest first:
1. reset: SR, Cause, EPC and BadVAddr all become 0.
2. `exc_req`:
   - EXL ← 1.
   - BD ← bd_M.
   - EPC ← (bd_M ? pc_M−4 : pc_M) with bits [1:0] forced to 0.
   - ExcCode ← 0 if int_req, else exc_code_M. An interrupt wins over a simultaneous exception.
   - BadVAddr ← bad_addr_M only when the recorded code is 4 or 5.
3. `eret_M`: EXL ← 0.
4. `cp0_we`: write SR as {IM, EXL, IE} fields only, or write EPC with the full 32 bits.

Additional rules:
- A pending mtc0 or eret is discarded in a cycle where `exc_req` is 1.
- Cause.IP ← hw_int every cycle, reset included. It is masked to 0 while reset is high.
- Arithmetic is 32-bit modulo. pc_M−4 wraps at 0.

## Timing
- `exc_req` asserts in the same cycle as the qualifying inputs, with zero latency.
- Register effects of any event are visible on `cp0_rdata` and `epc_out` from the next cycle.
- An mfc0 in the same cycle as an mtc0 to the same register returns the old value. The hazard unit stalls or forwards as needed.
- After an exception, EXL=1 blocks further requests until eret. Nested exceptions are not recorded while EXL=1.
- After reset releases, all outputs are 0 except `cp0_rdata`, which is PRID when cp0_addr=15.
- If reset is asserted mid-handler (EXL=1), EXL clears and no EPC is retained.

## Structure
- A shared package or include holds:
  - cp0 register numbers 8, 12, 13, 14, 15;
  - the ExcCode constants;
  - the handler vector 32'h0000_4180;
  - the field bit positions.
- One sub-module, `cp0_int_arbiter`, is natural. It is combinational and produces int_req, exc_hit and the selected ExcCode. The register file and update logic stay in the top module.

## Test plan
- Reset, then mfc0 addr 15 → rdata=PRID. Addresses 12, 13, 14 read 0.
- mtc0 SR=32'h0000_0401 (IM[10], IE), then hw_int=6'b000001 with pc_M=32'h3010 → exc_req=1 in the same cycle. Next cycle: Cause.ExcCode=0, Cause.IP[10]=1, EPC=32'h3010, SR.EXL=1. With hw_int held, exc_req=0.
- exc_code_M=12 (Ov), bd_M=1, pc_M=32'h3024, EXL=0 → EPC=32'h3020, BD=1, ExcCode=12.
- exc_code_M=4, bad_addr_M=32'h0000_1003 → BadVAddr=32'h1003, ExcCode=4. A later Ov exception leaves BadVAddr unchanged.
- Simultaneous enabled interrupt and exc_code_M=10 → ExcCode=0. An mtc0 EPC issued in the same cycle is dropped.
- With EXL=1, eret_M → EXL=0 next cycle and epc_out unchanged. An enabled interrupt then fires on the following cycle. Reset asserted while EXL=1 clears all registers.
